// File: rtl/spi_xfer_ctrl_if.sv
// Request/strobe bundle between the SPI register block (master) and the
// transfer sequencer (slave).
interface spi_xfer_ctrl_if #(
  parameter int unsigned DIV_W = 8
);
  logic             start;
  logic [DIV_W-1:0] div;
  logic             cpol;
  logic             cpha;
  logic             sclk;
  logic             ss;
  logic             send_data;
  logic             receive_data;
  logic             mosi_send_sclk;
  logic             mosi_send_sclk0;
  logic             miso_recieve_sclk;
  logic             miso_recieve_sclk0;
  logic             busy;
  logic             done;

  modport master (
    output start, div, cpol, cpha,
    input  sclk, ss, send_data, receive_data, mosi_send_sclk, mosi_send_sclk0,
           miso_recieve_sclk, miso_recieve_sclk0, busy, done
  );

  modport slave (
    input  start, div, cpol, cpha,
    output sclk, ss, send_data, receive_data, mosi_send_sclk, mosi_send_sclk0,
           miso_recieve_sclk, miso_recieve_sclk0, busy, done
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// One-byte SPI transfer sequencer: sclk generation, slave select and shift-edge strobes.
// Define SPI_CTRL_B2B_EN to let a start during DONE chain the next byte without releasing ss.
module spi_xfer_ctrl #(
  parameter int unsigned DIV_W = 8
) (
  input logic           pclk,
  input logic           preset,
  spi_xfer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_e;

  typedef struct packed {
    logic tx_rise;
    logic tx_fall;
    logic rx_rise;
    logic rx_fall;
  } edge_pulse_t;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [3:0]       edges_q, edges_d;
  logic             last_q, last_d;
  logic             sclk_q, sclk_d;
  edge_pulse_t      pulse_q, pulse_d;
  logic             load;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    edges_d = edges_q;
    last_d  = last_q;
    sclk_d  = sclk_q;
    pulse_d = '0;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        sclk_d = bus.cpol;
        load   = bus.start;
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = XFER;
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      XFER: begin
        if (last_q) begin
          state_d = DONE;
        end else if (cnt_q == '0) begin
          cnt_d   = div_q;
          sclk_d  = ~sclk_q;
          edges_d = edges_q + 4'd1;
          last_d  = (edges_q == 4'd15);
          // Rising is the sample edge exactly when cpol equals cpha.
          if (!sclk_q) begin
            if (cpol_q == cpha_q) pulse_d.rx_rise = 1'b1;
            else                  pulse_d.tx_rise = 1'b1;
          end else begin
            if (cpol_q == cpha_q) pulse_d.tx_fall = 1'b1;
            else                  pulse_d.rx_fall = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef SPI_CTRL_B2B_EN
        load    = bus.start;
`endif
      end
    endcase

    if (load) begin
      state_d = SETUP;
      div_d   = bus.div;
      cnt_d   = bus.div;
      cpol_d  = bus.cpol;
      cpha_d  = bus.cpha;
      edges_d = '0;
      last_d  = 1'b0;
      sclk_d  = bus.cpol;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      edges_q <= '0;
      last_q  <= 1'b0;
      sclk_q  <= 1'b0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      edges_q <= edges_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.sclk               = sclk_q;
  assign bus.ss                 = (state_q == IDLE);
  assign bus.busy               = (state_q != IDLE);
  // The SETUP counter starts at the shadow divisor, so equality marks the first SETUP cycle.
  assign bus.send_data          = (state_q == SETUP) && (cnt_q == div_q);
  assign bus.receive_data       = (state_q == DONE);
  assign bus.done               = (state_q == DONE);
  assign bus.mosi_send_sclk     = pulse_q.tx_rise;
  assign bus.mosi_send_sclk0    = pulse_q.tx_fall;
  assign bus.miso_recieve_sclk  = pulse_q.rx_rise;
  assign bus.miso_recieve_sclk0 = pulse_q.rx_fall;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: directed timing scenarios plus random traffic, all checked
// each cycle against a cycle-offset model of one transfer.
module tb_spi_xfer_ctrl;
  localparam int DIV_W = 8;
`ifdef SPI_CTRL_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic pclk = 1'b0;
  logic preset;
  spi_xfer_ctrl_if #(.DIV_W(DIV_W)) bus ();
  spi_xfer_ctrl #(.DIV_W(DIV_W)) dut (.pclk(pclk), .preset(preset), .bus(bus));

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
  endtask

  // ---------------- reference model ----------------
  // Outputs of an active transfer are a pure function of k, the cycle offset from the
  // cycle in which start was accepted.
  bit m_on, m_cpol, m_cpha, m_idle_sclk, chk_en;
  int m_k, m_d;

  function automatic int xfer_len(int d);
    return 2 + 17 * (d + 1);
  endfunction

  // {sclk, ss, busy, send, recv, done, tx_rise, tx_fall, rx_rise, rx_fall}
  function automatic logic [9:0] model_out(bit on, int k, int d, bit c, bit h, bit idle_sclk);
    int p, n_done, edge_n;
    bit lead, rising, sample;
    logic [9:0] o;
    if (!on) return {idle_sclk, 1'b1, 8'b0};
    p = d + 1;
    n_done = 0;
    edge_n = 0;
    for (int n = 1; n <= 16; n++) begin
      if (1 + (n + 1) * p <= k) n_done++;
      if (1 + (n + 1) * p == k) edge_n = n;
    end
    o = '0;
    o[9] = c ^ n_done[0];
    o[7] = 1'b1;
    o[6] = (k == 1);
    o[5] = (k == xfer_len(d));
    o[4] = (k == xfer_len(d));
    if (edge_n != 0) begin
      lead   = edge_n[0];
      rising = lead ^ c;
      sample = lead ^ h;
      o[3] = rising & !sample;
      o[2] = !rising & !sample;
      o[1] = rising & sample;
      o[0] = !rising & sample;
    end
    return o;
  endfunction

  always @(posedge pclk) begin
    if (preset) begin
      m_on        <= 1'b0;
      m_idle_sclk <= 1'b0;
      chk_en      <= 1'b1;
    end else if (m_on && m_k == xfer_len(m_d)) begin
      if (B2B && bus.start) begin
        m_k    <= 1;
        m_d    <= int'(bus.div);
        m_cpol <= bus.cpol;
        m_cpha <= bus.cpha;
      end else begin
        m_on        <= 1'b0;
        m_idle_sclk <= m_cpol;
      end
    end else if (m_on) begin
      m_k <= m_k + 1;
    end else if (bus.start) begin
      m_on   <= 1'b1;
      m_k    <= 1;
      m_d    <= int'(bus.div);
      m_cpol <= bus.cpol;
      m_cpha <= bus.cpha;
    end else begin
      m_idle_sclk <= bus.cpol;
    end
  end

  logic [9:0] dut_vec;
  assign dut_vec = {bus.sclk, bus.ss, bus.busy, bus.send_data, bus.receive_data, bus.done,
                    bus.mosi_send_sclk, bus.mosi_send_sclk0,
                    bus.miso_recieve_sclk, bus.miso_recieve_sclk0};

  always @(negedge pclk)
    if (chk_en) check("outputs", 32'(dut_vec), 32'(model_out(m_on, m_k, m_d, m_cpol, m_cpha, m_idle_sclk)));

  // ---------------- stimulus helpers ----------------
  typedef struct {
    int done_cyc, ss_cyc, send_cyc, edges, tx_r, tx_f, rx_r, rx_f, e1, e2, dones;
  } meas_t;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_in(input bit s, input int d, input bit c, input bit h);
    bus.start = s;
    bus.div   = DIV_W'(d);
    bus.cpol  = c;
    bus.cpha  = h;
  endtask

  // Start one transfer from IDLE and measure it until ss returns high. At mid_cyc the
  // configuration inputs are disturbed; start is pulsed for 3 cycles from spur_cyc.
  task automatic run_xfer(input int d, input bit c, input bit h, input int mid_cyc,
                          input int spur_cyc, output meas_t m);
    logic prev_sclk;
    m = '{default: 0};
    m.done_cyc = -1;
    m.ss_cyc   = -1;
    m.send_cyc = -1;
    m.e1       = -1;
    m.e2       = -1;
    set_in(1'b1, d, c, h);
    prev_sclk = c;
    tick();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      if (bus.sclk !== prev_sclk) begin
        m.edges++;
        if (m.e1 < 0) m.e1 = cyc;
        else if (m.e2 < 0) m.e2 = cyc;
      end
      prev_sclk = bus.sclk;
      if (bus.send_data && m.send_cyc < 0) m.send_cyc = cyc;
      m.tx_r += int'(bus.mosi_send_sclk);
      m.tx_f += int'(bus.mosi_send_sclk0);
      m.rx_r += int'(bus.miso_recieve_sclk);
      m.rx_f += int'(bus.miso_recieve_sclk0);
      if (bus.done) begin
        m.dones++;
        if (m.done_cyc < 0) m.done_cyc = cyc;
      end
      if (bus.ss && m.done_cyc >= 0) begin
        m.ss_cyc = cyc;
        break;
      end
      if (cyc == mid_cyc) begin
        bus.div  = DIV_W'(d + 2);
        bus.cpol = ~c;
        bus.cpha = ~h;
      end
      bus.start = (cyc >= spur_cyc && cyc < spur_cyc + 3);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    meas_t m;
    int run, max_run, dones;

    set_in(1'b0, 0, 1'b0, 1'b0);
    preset = 1'b1;
    repeat (3) tick();
    check("reset_ss",   bus.ss,   1);
    check("reset_sclk", bus.sclk, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    preset = 1'b0;
    tick();

    // Minimum divisor, mode 0.
    run_xfer(0, 1'b0, 1'b0, -1, -100, m);
    check("t1_send_cyc", m.send_cyc, 1);
    check("t1_first_edge", m.e1, 3);
    check("t1_edges", m.edges, 16);
    check("t1_tx_fall", m.tx_f, 8);
    check("t1_rx_rise", m.rx_r, 8);
    check("t1_other_pulses", m.tx_r + m.rx_f, 0);
    check("t1_done_cyc", m.done_cyc, 19);
    check("t1_ss_cyc", m.ss_cyc, 20);

    // div=3, mode 3: idles high, 4-cycle half period.
    bus.cpol = 1'b1;
    repeat (2) tick();
    check("t2_idle_sclk", bus.sclk, 1);
    run_xfer(3, 1'b1, 1'b1, -1, -100, m);
    check("t2_first_edge", m.e1, 9);
    check("t2_half_period", m.e2 - m.e1, 4);
    check("t2_tx_fall", m.tx_f, 8);
    check("t2_rx_rise", m.rx_r, 8);
    check("t2_other_pulses", m.tx_r + m.rx_f, 0);
    check("t2_done_cyc", m.done_cyc, 70);

    // start held high continuously.
    set_in(1'b1, 0, 1'b0, 1'b0);
    run = 0; max_run = 0; dones = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      tick();
      if (bus.ss) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      dones += int'(bus.done);
    end
    check("t3_ss_gap", max_run, B2B ? 0 : 1);
    check("t3_dones", dones, 3);
    bus.start = 1'b0;
    for (int i = 0; i < 100 && !bus.ss; i++) tick();
    check("t3_idle", bus.ss, 1);

    // Mid-transfer config changes, then a transfer with the new values.
    run_xfer(2, 1'b0, 1'b1, 10, -100, m);
    check("t4_first_edge", m.e1, 7);
    check("t4_tx_rise", m.tx_r, 8);
    check("t4_rx_fall", m.rx_f, 8);
    check("t4_done_cyc", m.done_cyc, 53);
    run_xfer(4, 1'b1, 1'b0, -1, -100, m);
    check("t4b_tx_rise", m.tx_r, 8);
    check("t4b_rx_fall", m.rx_f, 8);
    check("t4b_done_cyc", m.done_cyc, 87);

    // Reset at edge 7 abandons the transfer.
    set_in(1'b1, 1, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    repeat (16) tick();
    check("t5_edge7_sclk", bus.sclk, 1);
    check("t5_edge7_rx_rise", bus.miso_recieve_sclk, 1);
    preset = 1'b1;
    tick();
    preset = 1'b0;
    check("t5_ss", bus.ss, 1);
    check("t5_sclk", bus.sclk, 0);
    check("t5_busy", bus.busy, 0);
    dones = 0;
    repeat (60) begin
      tick();
      dones += int'(bus.done) + int'(bus.receive_data);
    end
    check("t5_no_done", dones, 0);

    // start during XFER is ignored.
    run_xfer(1, 1'b1, 1'b1, -1, 12, m);
    check("t6_dones", m.dones, 1);
    check("t6_done_cyc", m.done_cyc, 36);

    // Maximum divisor: half period of 256 cycles.
    run_xfer(255, 1'b0, 1'b0, -1, -100, m);
    check("t7_first_edge", m.e1, 513);
    check("t7_half_period", m.e2 - m.e1, 256);
    check("t7_done_cyc", m.done_cyc, 4354);

    // Random traffic with occasional resets; the compare process checks every cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      set_in($urandom_range(0, 3) == 0, int'($urandom_range(0, 4)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      preset = ($urandom_range(0, 299) == 0);
      tick();
    end
    preset = 1'b0;
    bus.start = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
